// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: widths and ALU operation encodings.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_CTRL_W = 4;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source forwarding select: MEM result beats WB result beats the
// registered register-file value. x0 is never forwarded.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::XLEN
) (
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [DW-1:0]         reg_data_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [DW-1:0]         mem_data_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DW-1:0]         wb_data_i,
    output logic [DW-1:0]         data_o
);

    logic rs_nonzero;
    assign rs_nonzero = (rs_addr_i != '0);

    // Priority select; the MEM check comes last so it overrides a WB match.
    always_comb begin
        data_o = reg_data_i;
        if (rs_nonzero && wb_we_i && (wb_rd_i == rs_addr_i)) begin
            data_o = wb_data_i;
        end
        if (rs_nonzero && mem_we_i && (mem_rd_i == rs_addr_i)) begin
            data_o = mem_data_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select.
// Optional feature macro: EXOP_FWD_EN enables MEM/WB forwarding and the
// sticky reload of held operands while stalled. Without it the forwarding
// ports are ignored and operands come straight from the captured
// register-file reads (upstream is expected to stall on hazards).
module ex_operand_stage #(
    parameter int XLEN       = cpu_pkg::XLEN,
    parameter int ALU_CTRL_W = cpu_pkg::ALU_CTRL_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          id_valid,
    output logic                          id_ready,
    input  logic [XLEN-1:0]               id_pc,
    input  logic [XLEN-1:0]               id_rs1_data,
    input  logic [XLEN-1:0]               id_rs2_data,
    input  logic [XLEN-1:0]               id_imm,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] id_rd_addr,
    input  logic                          id_reg_write,
    input  logic [ALU_CTRL_W-1:0]         id_alu_ctrl,
    input  logic                          id_src_a_pc,
    input  logic                          id_src_b_imm,
    input  logic                          mem_fwd_we,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]               mem_fwd_data,
    input  logic                          wb_fwd_we,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]               wb_fwd_data,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [XLEN-1:0]               alu_a,
    output logic [XLEN-1:0]               alu_b,
    output logic [ALU_CTRL_W-1:0]         alu_control,
    output logic [XLEN-1:0]               ex_rs2_val,
    output logic [cpu_pkg::REG_ADDR_W-1:0] ex_rd_addr,
    output logic                          ex_reg_write
);

    import cpu_pkg::*;

    // Held instruction state
    logic                  valid_q,     valid_d;
    logic [XLEN-1:0]       pc_q,        pc_d;
    logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]       imm_q,       imm_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic                  reg_write_q, reg_write_d;
    logic [ALU_CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic                  src_a_pc_q,  src_a_pc_d;
    logic                  src_b_imm_q, src_b_imm_d;

    // Forwarding bus as seen by the muxes (tied off when forwarding is disabled)
    logic                  mem_we_eff;
    logic [REG_ADDR_W-1:0] mem_rd_eff;
    logic [XLEN-1:0]       mem_data_eff;
    logic                  wb_we_eff;
    logic [REG_ADDR_W-1:0] wb_rd_eff;
    logic [XLEN-1:0]       wb_data_eff;

    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;

`ifdef EXOP_FWD_EN
    assign mem_we_eff   = mem_fwd_we;
    assign mem_rd_eff   = mem_fwd_rd;
    assign mem_data_eff = mem_fwd_data;
    assign wb_we_eff    = wb_fwd_we;
    assign wb_rd_eff    = wb_fwd_rd;
    assign wb_data_eff  = wb_fwd_data;
`else
    logic unused_fwd_ports;
    assign unused_fwd_ports = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                                wb_fwd_we, wb_fwd_rd, wb_fwd_data};
    assign mem_we_eff   = 1'b0;
    assign mem_rd_eff   = '0;
    assign mem_data_eff = '0;
    assign wb_we_eff    = 1'b0;
    assign wb_rd_eff    = '0;
    assign wb_data_eff  = '0;
`endif

    operand_fwd_mux #(.DW(XLEN)) u_fwd_rs1 (
        .rs_addr_i  (rs1_addr_q),
        .reg_data_i (rs1_data_q),
        .mem_we_i   (mem_we_eff),
        .mem_rd_i   (mem_rd_eff),
        .mem_data_i (mem_data_eff),
        .wb_we_i    (wb_we_eff),
        .wb_rd_i    (wb_rd_eff),
        .wb_data_i  (wb_data_eff),
        .data_o     (fwd_rs1)
    );

    operand_fwd_mux #(.DW(XLEN)) u_fwd_rs2 (
        .rs_addr_i  (rs2_addr_q),
        .reg_data_i (rs2_data_q),
        .mem_we_i   (mem_we_eff),
        .mem_rd_i   (mem_rd_eff),
        .mem_data_i (mem_data_eff),
        .wb_we_i    (wb_we_eff),
        .wb_rd_i    (wb_rd_eff),
        .wb_data_i  (wb_data_eff),
        .data_o     (fwd_rs2)
    );

    assign id_ready = !valid_q || ex_ready;

    // Next-state: capture/bubble when ready, reload forwarded operands while
    // holding so a stalled instruction keeps results that later leave MEM/WB;
    // flush overrides everything for the valid bit only.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        alu_ctrl_d  = alu_ctrl_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        if (id_ready) begin
            valid_d = id_valid;
            if (id_valid) begin
                pc_d        = id_pc;
                rs1_data_d  = id_rs1_data;
                rs2_data_d  = id_rs2_data;
                imm_d       = id_imm;
                rs1_addr_d  = id_rs1_addr;
                rs2_addr_d  = id_rs2_addr;
                rd_addr_d   = id_rd_addr;
                reg_write_d = id_reg_write;
                alu_ctrl_d  = id_alu_ctrl;
                src_a_pc_d  = id_src_a_pc;
                src_b_imm_d = id_src_b_imm;
            end
        end else begin
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register; reset clears every field so nothing survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            alu_ctrl_q  <= ALU_CTRL_W'(ALU_ADD);
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            alu_ctrl_q  <= alu_ctrl_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_a        = src_a_pc_q  ? pc_q  : fwd_rs1;
    assign alu_b        = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_rs2_val   = fwd_rs2;
    assign alu_control  = alu_ctrl_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = valid_q && reg_write_q;

endmodule
